// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: four-slot ROM request arbiter with a one-word cache per slot.
// Cache misses are sent one at a time to the single SDRAM read port.
// refresh_en is raised only when the port is idle and no slot is waiting.
// Optional macro JTFRAME_ARB_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority with slot 0 highest.

// Per-slot cache: stores the last fetched word and its address.
module jtframe_rom_arb_slot #(
  parameter int AW = 22,
  parameter int DW = 32
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  input  logic          fill,
  input  logic [AW-1:0] faddr,
  input  logic [DW-1:0] fdata,
  output logic [DW-1:0] dout,
  output logic          ok
);
  logic          valid;
  logic [AW-1:0] caddr;

  // Capture a fill.
  // While downloading, keep valid clear so any word arriving late is never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      caddr <= '0;
      dout  <= '0;
    end else begin
      if (fill) begin
        caddr <= faddr;
        dout  <= fdata;
      end
      if (clr)       valid <= 1'b0;
      else if (fill) valid <= 1'b1;
    end
  end

  assign ok = cs & valid & (addr == caddr);
endmodule

module jtframe_rom_arb #(
  parameter int AW = 22,
  parameter int DW = 32
)(
  input  logic          rst,
  input  logic          clk_rom,
  input  logic          downloading,
  input  logic          loop_rst,
  input  logic [3:0]    slot_cs,
  input  logic [4*AW-1:0] slot_addr,
  output logic [4*DW-1:0] slot_dout,
  output logic [3:0]    slot_ok,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic [AW-1:0] sdram_addr,
  input  logic [DW-1:0] data_read,
  input  logic          data_rdy,
  output logic          refresh_en
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;

  st_t                 st;
  logic [1:0]          gnt, win;
  logic [3:0]          miss, fill_v;
  logic                fill;
  logic [3:0][AW-1:0]  addr_a;
  logic [3:0][DW-1:0]  dout_a;

  assign addr_a    = slot_addr;
  assign slot_dout = dout_a;
  assign miss      = slot_cs & ~slot_ok;

  // Data is accepted in WAIT.
  // It is also accepted in REQ when ack and data arrive in the same cycle.
  assign fill = data_rdy & ((st == WAIT) | ((st == REQ) & sdram_ack));

  // Refresh is allowed only when the port is free and no slot is waiting.
  // It is held low during reset and downloading.
  assign refresh_en = ~rst & ~downloading & (st == IDLE) & ~|miss;

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_slot
      assign fill_v[n] = fill & (gnt == 2'(n));
      jtframe_rom_arb_slot #(.AW(AW), .DW(DW)) u_slot (
        .clk   (clk_rom),
        .rst   (rst),
        .cs    (slot_cs[n]),
        .addr  (addr_a[n]),
        .clr   (downloading),
        .fill  (fill_v[n]),
        .faddr (sdram_addr),
        .fdata (data_read),
        .dout  (dout_a[n]),
        .ok    (slot_ok[n])
      );
    end
  endgenerate

`ifdef JTFRAME_ARB_RR_EN
  logic [1:0] last_gnt;

  // Round-robin: the search starts at the slot after the last grant.
  // The descending loop leaves the closest miss as the winner.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_gnt + 2'(k) + 2'd1;
      if (miss[idx]) win = idx;
    end
  end

  // Remember the most recent grant for the next search.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) last_gnt <= '0;
    else if (st == IDLE && !downloading && !loop_rst && |miss) last_gnt <= win;
  end
`else
  // Fixed priority: the lowest-numbered missing slot wins.
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--)
      if (miss[k]) win = 2'(k);
  end
`endif

  // Request sequencer: grant, then handshake, then wait for data, one miss at a time.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt        <= '0;
    end else begin
      case (st)
        IDLE: if (!downloading && !loop_rst && |miss) begin
          sdram_addr <= addr_a[win];
          gnt        <= win;
          sdram_req  <= 1'b1;
          st         <= REQ;
        end
        REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          st        <= data_rdy ? IDLE : WAIT;
        end
        WAIT: if (data_rdy) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
